// File: rtl/avr_hvpp_sequencer.sv
// rtl/avr_hvpp_sequencer.sv - AVR high-voltage parallel programming sequencer
// Turns single host commands into timed XTAL/WR/OE/PAGEL pin sequences and polls RDY/BSY.
module avr_hvpp_sequencer #(
  parameter int XTAL_HALF = 4,
  parameter int WR_PULSE  = 8,
  parameter int OE_SETUP  = 6,
  parameter int BSY_WAIT  = 64,
  parameter int TIMEOUT   = 65535
) (
  input  logic       osc_in,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  input  logic [7:0] dut_din,
  input  logic       dut_rdy,
  output logic [7:0] dut_dout,
  output logic       dut_doe,
  output logic       dut_xtal,
  output logic       dut_wr_n,
  output logic       dut_oe_n,
  output logic       dut_pagel,
  output logic       dut_xa0,
  output logic       dut_xa1,
  output logic       dut_bs1,
  output logic       dut_bs2
);

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_XTAL_HI, S_XTAL_LO, S_WR_LO,
    S_WAIT_BSY, S_WAIT_RDY, S_OE_WAIT, S_PAGEL_HI, S_DONE
  } state_t;

  // Counts are loaded with N-1 so a state lasts exactly N cycles.
  localparam logic [15:0] XH_LD  = 16'(XTAL_HALF - 1);
  localparam logic [15:0] WR_LD  = 16'(WR_PULSE - 1);
  localparam logic [15:0] OE_LD  = 16'(OE_SETUP - 1);
  localparam logic [15:0] BSY_LD = 16'(BSY_WAIT - 1);
  localparam logic [15:0] TO_LD  = 16'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  op_q;
  logic        rdy_s1, rdy_s2;
  logic        accept, err_set, cnt_zero;
  logic [3:0]  pin_sel;

  assign accept    = (state == S_IDLE) && cmd_valid;
  assign cnt_zero  = (cnt == 16'd0);
  assign cmd_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_DONE);
  assign dut_xtal  = (state == S_XTAL_HI);
  assign dut_wr_n  = (state != S_WR_LO);
  assign dut_oe_n  = (state != S_OE_WAIT);
  assign dut_pagel = (state == S_PAGEL_HI);

  always_ff @(posedge osc_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 16'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt_zero ? 16'd0 : cnt - 16'd1;
    err_set = 1'b0;
    // {xa1, xa0, bs1, bs2} applied at accept; unlisted pins keep their value
    case (cmd_op)
      3'd0:       pin_sel = 4'b1000;
      3'd1:       pin_sel = 4'b0000;
      3'd2:       pin_sel = 4'b0010;
      3'd3:       pin_sel = 4'b0100;
      3'd4:       pin_sel = 4'b0110;
      3'd5, 3'd6: pin_sel = {2'b00, cmd_data[0], cmd_data[1]};
      default:    pin_sel = {dut_xa1, dut_xa0, 1'b1, dut_bs2};
    endcase
    case (state)
      S_IDLE:     if (cmd_valid) state_n = S_SETUP;
      S_SETUP: begin
        case (op_q)
          3'd5:    state_n = S_WR_LO;
          3'd6:    state_n = S_OE_WAIT;
          3'd7:    state_n = S_PAGEL_HI;
          default: state_n = S_XTAL_HI;
        endcase
      end
      S_XTAL_HI:  if (cnt_zero) state_n = S_XTAL_LO;
      S_XTAL_LO:  if (cnt_zero) state_n = S_DONE;
      S_WR_LO:    if (cnt_zero) state_n = S_WAIT_BSY;
      S_WAIT_BSY: if (!rdy_s2 || cnt_zero) state_n = S_WAIT_RDY;
      S_WAIT_RDY: begin
        if (rdy_s2) begin
          state_n = S_DONE;
        end else if (cnt_zero) begin
          state_n = S_DONE;
          err_set = 1'b1;
        end
      end
      S_OE_WAIT:  if (cnt_zero) state_n = S_DONE;
      S_PAGEL_HI: if (cnt_zero) state_n = S_DONE;
      S_DONE:     state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
    if (state_n != state) begin
      case (state_n)
        S_XTAL_HI, S_XTAL_LO, S_PAGEL_HI: cnt_n = XH_LD;
        S_WR_LO:    cnt_n = WR_LD;
        S_OE_WAIT:  cnt_n = OE_LD;
        S_WAIT_BSY: cnt_n = BSY_LD;
        S_WAIT_RDY: cnt_n = TO_LD;
        default:    cnt_n = 16'd0;
      endcase
    end
  end

  always_ff @(posedge osc_in or negedge rst_n) begin
    if (!rst_n) begin
      rdy_s1   <= 1'b0;
      rdy_s2   <= 1'b0;
      op_q     <= 3'd0;
      dut_xa1  <= 1'b0;
      dut_xa0  <= 1'b0;
      dut_bs1  <= 1'b0;
      dut_bs2  <= 1'b0;
      dut_dout <= 8'd0;
      dut_doe  <= 1'b0;
      rsp_data <= 8'd0;
      rsp_err  <= 1'b0;
    end else begin
      rdy_s1 <= dut_rdy;
      rdy_s2 <= rdy_s1;
      if (accept) begin
        op_q <= cmd_op;
        {dut_xa1, dut_xa0, dut_bs1, dut_bs2} <= pin_sel;
        dut_doe  <= (cmd_op <= 3'd4);
        rsp_data <= 8'd0;
        rsp_err  <= 1'b0;
        if (cmd_op <= 3'd4) dut_dout <= cmd_data;
      end
      if (state == S_DONE) dut_doe <= 1'b0;
      if (state == S_OE_WAIT && cnt_zero) rsp_data <= dut_din;
      if (err_set) rsp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_avr_hvpp_sequencer.sv
// tb/tb_avr_hvpp_sequencer.sv - randomized self-checking bench for avr_hvpp_sequencer
// Expected latencies and pin activity come from a per-command timing model over cycle indices.
module tb_avr_hvpp_sequencer;

  localparam int XH = 4;
  localparam int WP = 8;
  localparam int OS = 6;
  localparam int BW = 64;
  localparam int TO = 100;

  logic       osc_in = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic [7:0] cmd_data = 8'd0;
  logic [7:0] dut_din = 8'd0;
  logic       dut_rdy = 1'b1;
  logic       cmd_ready, rsp_valid, rsp_err;
  logic [7:0] rsp_data, dut_dout;
  logic       dut_doe, dut_xtal, dut_wr_n, dut_oe_n, dut_pagel;
  logic       dut_xa0, dut_xa1, dut_bs1, dut_bs2;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] last_dout = 8'd0;

  avr_hvpp_sequencer #(
    .XTAL_HALF(XH), .WR_PULSE(WP), .OE_SETUP(OS), .BSY_WAIT(BW), .TIMEOUT(TO)
  ) dut (
    .osc_in(osc_in), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .dut_din(dut_din), .dut_rdy(dut_rdy), .dut_dout(dut_dout), .dut_doe(dut_doe),
    .dut_xtal(dut_xtal), .dut_wr_n(dut_wr_n), .dut_oe_n(dut_oe_n), .dut_pagel(dut_pagel),
    .dut_xa0(dut_xa0), .dut_xa1(dut_xa1), .dut_bs1(dut_bs1), .dut_bs2(dut_bs2)
  );

  always #5 osc_in = ~osc_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RDY as driven during cycle c (relative to the accept cycle): low in [s, e)
  function automatic logic raw_rdy(input int c, input int s, input int e);
    return !(c >= s && c < e);
  endfunction

  task automatic run_cmd(input logic [2:0] op, input logic [7:0] data, input int lo_s, input int lo_e);
    int n, d, exp_d, t1, n_xtal, n_wr, n_oe, n_pagel, n_doe_bad, n_conflict, wr_rise;
    logic exp_err, got_err;
    logic [7:0] din_h [0:15];
    logic [7:0] got_data, exp_data, dout1, exp_dout;
    logic [3:0] pins1, exp_pins, mask;

    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    dut_rdy   = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge osc_in);
      n++;
    end
    check("accept_wait", n, 0);
    dut_rdy = raw_rdy(0, lo_s, lo_e);
    dut_din = 8'($urandom);
    d = -1; n_xtal = 0; n_wr = 0; n_oe = 0; n_pagel = 0; n_doe_bad = 0; n_conflict = 0;
    pins1 = 4'd0; dout1 = 8'd0; got_data = 8'd0; got_err = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge osc_in);
      cmd_op   = 3'($urandom);
      cmd_data = 8'($urandom);
      dut_rdy  = raw_rdy(c, lo_s, lo_e);
      dut_din  = 8'($urandom);
      if (c < 16) din_h[c] = dut_din;
      if (c == 1) begin
        pins1 = {dut_xa1, dut_xa0, dut_bs1, dut_bs2};
        dout1 = dut_dout;
      end
      n_xtal  += int'(dut_xtal);
      n_wr    += int'(!dut_wr_n);
      n_oe    += int'(!dut_oe_n);
      n_pagel += int'(dut_pagel);
      n_conflict += int'(dut_doe && !dut_oe_n);
      if (dut_doe != (op <= 3'd4)) n_doe_bad++;
      if (rsp_valid) begin
        d = c;
        got_data = rsp_data;
        got_err = rsp_err;
        break;
      end
    end

    exp_err  = 1'b0;
    exp_data = (op == 3'd6) ? din_h[OS + 1] : 8'd0;
    case (op)
      3'd5: begin
        wr_rise = 2 + WP;
        t1 = wr_rise + BW;
        for (int k = wr_rise; k < wr_rise + BW; k++)
          if (!raw_rdy(k - 2, lo_s, lo_e)) begin t1 = k + 1; break; end
        exp_d = t1 + TO;
        exp_err = 1'b1;
        for (int k = t1; k < t1 + TO; k++)
          if (raw_rdy(k - 2, lo_s, lo_e)) begin exp_d = k + 1; exp_err = 1'b0; break; end
      end
      3'd6:    exp_d = OS + 2;
      3'd7:    exp_d = XH + 2;
      default: exp_d = 2 * XH + 2;
    endcase
    case (op)
      3'd0:       begin exp_pins = 4'b1000; mask = 4'b1110; end
      3'd1:       begin exp_pins = 4'b0000; mask = 4'b1110; end
      3'd2:       begin exp_pins = 4'b0010; mask = 4'b1110; end
      3'd3:       begin exp_pins = 4'b0100; mask = 4'b1110; end
      3'd4:       begin exp_pins = 4'b0110; mask = 4'b1110; end
      3'd5, 3'd6: begin exp_pins = {2'b00, data[0], data[1]}; mask = 4'b0011; end
      default:    begin exp_pins = 4'b0010; mask = 4'b0010; end
    endcase
    exp_dout = (op <= 3'd4) ? data : last_dout;

    if (d < 0) begin
      check("rsp_valid_seen", 0, 1);
    end else begin
      check("rsp_latency", d, exp_d);
      check("rsp_err", got_err, exp_err);
      check("rsp_data", got_data, exp_data);
      check("xtal_cycles", n_xtal, (op <= 3'd4) ? XH : 0);
      check("wr_low_cycles", n_wr, (op == 3'd5) ? WP : 0);
      check("oe_low_cycles", n_oe, (op == 3'd6) ? OS : 0);
      check("pagel_cycles", n_pagel, (op == 3'd7) ? XH : 0);
      check("doe_level", n_doe_bad, 0);
      check("doe_oe_conflict", n_conflict, 0);
      check("setup_pins", pins1 & mask, exp_pins & mask);
      check("dout", dout1, exp_dout);
      @(negedge osc_in);
      dut_rdy = 1'b1;
      check("idle_after_done", {cmd_ready, rsp_valid}, 2'b10);
      check("pins_hold", {dut_xa1, dut_xa0, dut_bs1, dut_bs2} & mask, exp_pins & mask);
      check("dout_hold", dut_dout, exp_dout);
    end
    last_dout = exp_dout;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(negedge osc_in);
    check("rst_ready_rsp", {cmd_ready, rsp_valid, rsp_err}, 3'b100);
    check("rst_pins", {dut_xtal, dut_wr_n, dut_oe_n, dut_pagel, dut_xa0, dut_xa1, dut_bs1, dut_bs2, dut_doe},
          9'b011000000);
    check("rst_data", {dut_dout, rsp_data}, 16'h0000);
    rst_n = 1'b1;

    // Reset asserted in the middle of XTAL_HI must take effect immediately
    @(negedge osc_in);
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_data = 8'h40;
    @(negedge osc_in);
    cmd_valid = 1'b0;
    repeat (2) @(negedge osc_in);
    check("xtal_before_rst", dut_xtal, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", {dut_xtal, dut_doe, cmd_ready, rsp_valid, dut_dout}, {4'b0010, 8'h00});
    repeat (3) @(negedge osc_in);
    check("mid_rst_no_rsp", rsp_valid, 1'b0);
    rst_n = 1'b1;
    last_dout = 8'd0;
    @(negedge osc_in);

    run_cmd(3'd0, 8'h40, 1 << 30, 1 << 30);
    run_cmd(3'd5, 8'h00, 10, 30);
    run_cmd(3'd5, 8'h03, 10, 1 << 30);
    run_cmd(3'd6, 8'h01, 0, 0);
    run_cmd(3'd1, 8'h12, 0, 0);
    run_cmd(3'd3, 8'h34, 0, 0);
    run_cmd(3'd7, 8'h00, 0, 0);
    run_cmd(3'd5, 8'h02, 0, 0);
    for (int i = 0; i < 60; i++) begin
      int s;
      s = 10 + int'($urandom_range(0, 6));
      run_cmd(3'($urandom_range(0, 7)), 8'($urandom), s, s + int'($urandom_range(0, 120)));
    end
    cmd_valid = 1'b0;
    repeat (2) @(negedge osc_in);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
